fetch_queue: RTL and testbench

//  Parametrised fetch stage with an in-order prefetch queue between PC generation and decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry layout for the fetch stage
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Queue entries are packed pc-high, instr-low; the top level uses the same order.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer with wrap-bit pointers and synchronous flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              full;
    logic              push_en;
    logic              pop_en;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_en  = push && !full && !flush;
        pop_en   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based in-order prefetch queue between PC generation and decode
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int             PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_instr,
    output logic            instr_valid,
    input  logic            decode_ready,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] inc_PCD
);

    localparam int CW = cnt_width(DEPTH);
    localparam int EW = 2 * XLEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   count;
    logic [CW-1:0]   shadow_count;
    logic            q_empty;
    logic            shadow_empty;
    logic [EW-1:0]   head_entry;
    logic [EW-1:0]   push_entry;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic            credit_ok;
    logic            issue;
    logic            drop_rsp;
    logic            push;
    logic            pop;

    // Every in-flight fetch owns a queue slot, so a response always has room.
    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = rst && !redirect_valid && credit_ok;
    assign imem_addr      = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    assign drop_rsp   = redirect_valid || (drop_cnt_q != '0);
    assign push       = imem_rsp_valid && !drop_rsp;
    assign pop        = !q_empty && decode_ready && !redirect_valid;
    assign push_entry = {rsp_pc, imem_rsp_instr};

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = outstanding_d;
        end else begin
            if (issue) begin
                pc_d = pc_q + XLEN'(PC_STEP);
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .empty     (q_empty),
        .count     (count)
    );

    // Addresses of issued fetches; never flushed, since stale responses still retire here.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (1'b0),
        .push      (issue),
        .push_data (pc_q),
        .pop       (imem_rsp_valid),
        .head_data (rsp_pc),
        .empty     (shadow_empty),
        .count     (shadow_count)
    );

    assign head_pc     = head_entry[EW-1:XLEN];
    assign head_instr  = head_entry[XLEN-1:0];
    assign instr_valid = !q_empty;
    assign InstrD      = instr_valid ? head_instr : XLEN'(NOP_INSTR);
    assign PCD         = instr_valid ? head_pc : '0;
    assign inc_PCD     = PCD + XLEN'(PC_STEP);

    sva_credit: assert property (@(posedge clk) disable iff (!rst)
        ({1'b0, count} + {1'b0, outstanding_q}) <= (CW+1)'(DEPTH));

    sva_shadow: assert property (@(posedge clk) disable iff (!rst)
        shadow_count == outstanding_q);

    sva_rsp_order: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> !shadow_empty);

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a program-order model
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        instr_valid;
    logic        decode_ready;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] inc_PCD;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .instr_valid    (instr_valid),
        .decode_ready   (decode_ready),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .inc_PCD        (inc_PCD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       memq[$];
    int          cyc;
    int          last_due;
    int          epoch;
    int          queued;
    int          checks;
    int          failures;
    int          n_issue;
    int          n_pop;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] wrap_inc;
    bit          saw_zero_after_wrap;
    bit          saw_wrap;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle; called at the falling edge, returns at the next falling edge.
    task automatic tick(input bit rdy, input bit dr, input bit redir,
                        input logic [31:0] tgt, input int lat);
        bit    rsp;
        int    due;
        mreq_t m;
        imem_req_ready = rdy;
        decode_ready   = dr;
        redirect_valid = redir;
        redirect_pc    = tgt;
        rsp            = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_instr = rsp ? mem_fn(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        check("instr_valid", {31'b0, instr_valid}, {31'b0, queued > 0});
        check("req_valid", {31'b0, imem_req_valid},
              {31'b0, !redir && (queued + memq.size() < DEPTH)});
        check("inc_pcd", inc_PCD, PCD + 32'd4);
        if (queued == 0) check("nop_idle", InstrD, NOP);
        if (queued > 0 && dr && !redir) begin
            check("pcd", PCD, exp_pc);
            check("instrd", InstrD, mem_fn(exp_pc));
            if (saw_wrap && PCD == 32'h0) saw_zero_after_wrap = 1'b1;
            if (PCD == 32'hFFFF_FFFC) begin
                wrap_inc = inc_PCD;
                saw_wrap = 1'b1;
            end
            exp_pc += 32'd4;
            queued--;
            n_pop++;
        end
        if (imem_req_valid && rdy) begin
            check("imem_addr", imem_addr, exp_req_pc);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            memq.push_back('{imem_addr, due, epoch});
            last_due = due;
            exp_req_pc += 32'd4;
            n_issue++;
        end
        if (rsp) begin
            m = memq.pop_front();
            if (m.epoch == epoch && !redir) queued++;
        end
        if (redir) begin
            epoch++;
            queued     = 0;
            exp_pc     = tgt;
            exp_req_pc = tgt;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset is asserted between clock edges; outputs must follow immediately.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instrd", InstrD, NOP);
        check("rst_pcd", PCD, 32'h0);
        check("rst_inc_pcd", inc_PCD, 32'd4);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        memq.delete();
        queued     = 0;
        epoch++;
        exp_pc     = 32'h0;
        exp_req_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        last_due = cyc;
    endtask

    initial begin
        int p0;
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_instr = '0; decode_ready = 1'b0;
        cyc = 0; last_due = 0; epoch = 0; queued = 0; checks = 0; failures = 0;
        n_issue = 0; n_pop = 0; exp_pc = '0; exp_req_pc = '0;
        wrap_inc = 32'hFFFF_FFFF; saw_wrap = 1'b0; saw_zero_after_wrap = 1'b0;
        @(negedge clk);

        // Streaming with a 1-cycle memory: six pops in the first eight cycles.
        do_reset();
        p0 = n_pop;
        for (int i = 0; i < 8; i++) tick(1, 1, 0, '0, 1);
        check("t1_pops", n_pop - p0, 32'd6);

        // Decode stall: issue stops at DEPTH requests.
        do_reset();
        p0 = n_issue;
        for (int i = 0; i < 10; i++) tick(1, 0, 0, '0, 1);
        check("t2_issued", n_issue - p0, 32'd4);
        for (int i = 0; i < 8; i++) tick(1, 1, 0, '0, 1);

        // Redirect with two fetches in flight on a 3-cycle memory.
        do_reset();
        tick(1, 1, 0, '0, 3);
        tick(1, 1, 0, '0, 3);
        check("t3_outstanding", memq.size(), 32'd2);
        tick(1, 1, 1, 32'h100, 3);
        p0 = n_pop;
        for (int i = 0; i < 12; i++) tick(1, 1, 0, '0, 3);
        check("t3_pops", {31'b0, (n_pop - p0) >= 2}, 32'd1);

        // Redirect coinciding with a response and a pop.
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 1, 0, '0, 1);
        tick(1, 1, 1, 32'h200, 1);
        #1;
        check("t4_valid", {31'b0, instr_valid}, 32'd0);
        check("t4_nop", InstrD, NOP);
        for (int i = 0; i < 6; i++) tick(1, 1, 0, '0, 1);

        // Address wrap at the top of the address space.
        tick(1, 1, 1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 10; i++) tick(1, 1, 0, '0, 1);
        check("t5_wrap_inc", wrap_inc, 32'h0);
        check("t5_zero_seen", {31'b0, saw_zero_after_wrap}, 32'd1);

        // Async reset with the queue half full.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 0, 0, '0, 1);
        check("t6_half_full", {31'b0, instr_valid}, 32'd1);
        do_reset();
        for (int i = 0; i < 6; i++) tick(1, 1, 0, '0, 1);

        // Random traffic, latency and redirects.
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, $urandom & 32'hFFFF_FFFC,
                 int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
